// File: rtl/pa_fpu.sv
// rtl/pa_fpu.sv - shared fpu operation encoding, initiator states and request format
// Purpose: types and constants used by the fpu command initiator and its request FIFO.
// Ports: none (package).
package pa_fpu;

  typedef enum logic [2:0] {
    FPU_OP_ADD  = 3'd0,
    FPU_OP_SUB  = 3'd1,
    FPU_OP_MUL  = 3'd2,
    FPU_OP_DIV  = 3'd3,
    FPU_OP_SQRT = 3'd4
  } e_fpu_op;

  typedef enum logic [1:0] {
    INIT_IDLE,
    INIT_ISSUE,
    INIT_WAIT_END,
    INIT_RESP
  } e_fpu_init_state;

  // Widest caller tag any initiator instance may use; narrower tags are zero-extended.
  localparam int FPU_TAG_W_MAX = 8;

  // Quiet NaN reported as the result of an aborted operation.
  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic [31:0]              a;
    logic [31:0]              b;
    e_fpu_op                  op;
    logic [FPU_TAG_W_MAX-1:0] tag;
  } st_fpu_req;

endpackage

// File: rtl/fpu_req_fifo.sv
// rtl/fpu_req_fifo.sv - synchronous FIFO of queued fpu requests
// Purpose: holds accepted requests until the initiator FSM issues them.
// Ports: clk/arst_n clock and async active-low reset; push/push_data write side;
//        pop/pop_data read side (pop_data shows the head entry); full/empty flags.
module fpu_req_fifo
  import pa_fpu::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      arst_n,
  input  logic      push,
  input  st_fpu_req push_data,
  input  logic      pop,
  output st_fpu_req pop_data,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  st_fpu_req        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_C);
  // A pop from a full FIFO frees the head slot this cycle, so a push may land in it.
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/fpu_cmd_initiator.sv
// rtl/fpu_cmd_initiator.sv - bus-side initiator that queues and issues fpu operations
// Purpose: buffers requests, drives the fpu start/cmd_end/busy handshake one op at a
//          time, and returns each result (or a timeout NaN) on the response port.
// Ports: req_* request valid/ready port; fpu_* fpu command interface;
//        rsp_* response valid/ready port; irq pulse on response; seq_busy activity flag.
module fpu_cmd_initiator
  import pa_fpu::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TAG_W          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_a,
  input  logic [31:0]       req_b,
  input  pa_fpu::e_fpu_op   req_op,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              fpu_start,
  output logic [31:0]       fpu_a_operand,
  output logic [31:0]       fpu_b_operand,
  output pa_fpu::e_fpu_op   fpu_operation,
  input  logic              fpu_cmd_end,
  input  logic              fpu_busy,
  input  logic [31:0]       fpu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_timeout,
  output logic              irq,
  output logic              seq_busy
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  e_fpu_init_state  state_q, state_d;
  logic             start_q, start_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  e_fpu_op          op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic             rsp_timeout_q, rsp_timeout_d;
  logic             irq_q, irq_d;
  logic             rdy_en_q, rdy_en_d;

  st_fpu_req        push_req;
  st_fpu_req        pop_req;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             unused_tag_bits;

  assign push_req.a   = req_a;
  assign push_req.b   = req_b;
  assign push_req.op  = req_op;
  assign push_req.tag = FPU_TAG_W_MAX'(req_tag);

  // Issue only from IDLE and only while the fpu reports itself free.
  assign fifo_pop  = (state_q == INIT_IDLE) && !fifo_empty && !fpu_busy;
  // rdy_en_q keeps req_ready low during reset and until the first clock after it.
  assign req_ready = rdy_en_q && (!fifo_full || fifo_pop);
  assign fifo_push = req_valid && req_ready;

  assign unused_tag_bits = ^pop_req.tag;

  fpu_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .arst_n    (arst_n),
    .push      (fifo_push),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (pop_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    tag_d         = tag_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_result_d  = rsp_result_q;
    rsp_timeout_d = rsp_timeout_q;
    irq_d         = 1'b0;
    rdy_en_d      = 1'b1;

    case (state_q)
      INIT_IDLE: begin
        if (fifo_pop) begin
          a_d     = pop_req.a;
          b_d     = pop_req.b;
          op_d    = pop_req.op;
          tag_d   = pop_req.tag[TAG_W-1:0];
          start_d = 1'b1;
          tmo_d   = '0;
          state_d = INIT_ISSUE;
        end
      end
      INIT_ISSUE: begin
        if (fpu_cmd_end) begin
          start_d       = 1'b0;
          rsp_result_d  = fpu_result;
          rsp_timeout_d = 1'b0;
          state_d       = INIT_WAIT_END;
        end else if (tmo_q == TMO_LAST) begin
          start_d       = 1'b0;
          rsp_result_d  = FPU_QNAN;
          rsp_timeout_d = 1'b1;
          state_d       = INIT_WAIT_END;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      INIT_WAIT_END: begin
        // Let cmd_end and busy fall first so one completion is never seen twice.
        if (!fpu_cmd_end && !fpu_busy) begin
          rsp_valid_d = 1'b1;
          irq_d       = 1'b1;
          state_d     = INIT_RESP;
        end
      end
      INIT_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = INIT_IDLE;
        end
      end
      default: state_d = INIT_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q       <= INIT_IDLE;
      start_q       <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= FPU_OP_ADD;
      tag_q         <= '0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_timeout_q <= 1'b0;
      irq_q         <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_q       <= start_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      tag_q         <= tag_d;
      tmo_q         <= tmo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_timeout_q <= rsp_timeout_d;
      irq_q         <= irq_d;
      rdy_en_q      <= rdy_en_d;
    end
  end

  assign fpu_start     = start_q;
  assign fpu_a_operand = a_q;
  assign fpu_b_operand = b_q;
  assign fpu_operation = op_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_tag       = tag_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign irq           = irq_q;
  assign seq_busy      = !fifo_empty || (state_q != INIT_IDLE);

endmodule

// File: tb/tb_fpu_cmd_initiator.sv
// tb/tb_fpu_cmd_initiator.sv - directed self-checking bench for fpu_cmd_initiator
module tb_fpu_cmd_initiator;
  import pa_fpu::*;

  localparam int TAG_W   = 4;
  localparam int RSP_LAT = 5;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  e_fpu_op          req_op;
  logic [TAG_W-1:0] req_tag;
  logic             fpu_start;
  logic [31:0]      fpu_a_operand;
  logic [31:0]      fpu_b_operand;
  e_fpu_op          fpu_operation;
  logic             fpu_busy;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;
  logic             irq;
  logic             seq_busy;

  // Behavioural fpu responder state
  logic        r_active  = 1'b0;
  int          r_cnt     = 0;
  logic        r_cmd_end = 1'b0;
  logic        r_busy    = 1'b0;
  logic [31:0] r_res     = '0;
  logic        ext_busy  = 1'b0;
  logic        no_end    = 1'b0;

  int passed = 0;
  int total  = 0;
  int irq_cnt = 0;
  logic [TAG_W-1:0] got_tag [$];
  logic [31:0]      got_res [$];

  assign fpu_busy = r_busy | ext_busy;

  always #5 clk = ~clk;

  fpu_cmd_initiator #(
    .FIFO_DEPTH     (4),
    .TAG_W          (TAG_W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_op        (req_op),
    .req_tag       (req_tag),
    .fpu_start     (fpu_start),
    .fpu_a_operand (fpu_a_operand),
    .fpu_b_operand (fpu_b_operand),
    .fpu_operation (fpu_operation),
    .fpu_cmd_end   (r_cmd_end),
    .fpu_busy      (fpu_busy),
    .fpu_result    (r_res),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_result    (rsp_result),
    .rsp_tag       (rsp_tag),
    .rsp_timeout   (rsp_timeout),
    .irq           (irq),
    .seq_busy      (seq_busy)
  );

  // Known IEEE results for the operand pairs used; other ops return a ^ b.
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input e_fpu_op op);
    if (a == 32'h3F80_0000 && b == 32'h3F8C_CCCD && op == FPU_OP_ADD) return 32'h4006_6666;
    if (a == 32'h3F80_0000 && b == 32'h3F8C_CCCD && op == FPU_OP_SUB) return 32'hBDCC_CCD0;
    return a ^ b;
  endfunction

  always @(negedge clk) begin
    if (!arst_n) begin
      r_active  <= 1'b0;
      r_cnt     <= 0;
      r_cmd_end <= 1'b0;
      r_busy    <= 1'b0;
    end else if (r_active) begin
      if (r_cmd_end) begin
        r_cmd_end <= 1'b0;
        r_busy    <= 1'b0;
        r_active  <= 1'b0;
      end else if (!fpu_start) begin
        r_busy   <= 1'b0;
        r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1;
        if (r_cnt >= RSP_LAT - 1 && !no_end) begin
          r_cmd_end <= 1'b1;
          r_res     <= fpu_model(fpu_a_operand, fpu_b_operand, fpu_operation);
        end
      end
    end else if (fpu_start) begin
      r_active <= 1'b1;
      r_busy   <= 1'b1;
      r_cnt    <= 1;
    end
  end

  // Response/irq recorder: rsp_ready is stable at the falling edge, so a handshake
  // seen here completes on the following rising edge.
  always @(negedge clk) begin
    if (arst_n && rsp_valid && rsp_ready) begin
      got_tag.push_back(rsp_tag);
      got_res.push_back(rsp_result);
    end
    if (irq) irq_cnt <= irq_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input e_fpu_op op,
                      input logic [TAG_W-1:0] tag, input string name);
    int   n  = 0;
    logic ok = 1'b0;
    req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk); #1;
      if (req_ready) ok = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    req_valid = 1'b0;
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input string name);
    int n = 0;
    while (rsp_valid !== 1'b1 && n < 300) begin
      tick(1);
      n++;
    end
    chk(name, 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_q(input int target, input string name);
    int n = 0;
    while (got_tag.size() < target && n < 2000) begin
      tick(1);
      n++;
    end
    chk(name, 32'(got_tag.size()), 32'(target));
  endtask

  initial begin
    int n;
    int qb;
    int base_irq;

    arst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0;
    req_op = FPU_OP_ADD; req_tag = '0; rsp_ready = 1'b0;
    tick(2);

    // Reset state
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_fpu_start", 32'(fpu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("rst_fpu_op", 32'(fpu_operation), 32'd0);
    chk("rst_fpu_a", fpu_a_operand, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    arst_n = 1'b1;
    chk("rel_ready_before_clk", 32'(req_ready), 32'd0);
    tick(1);
    chk("rel_ready_after_clk", 32'(req_ready), 32'd1);

    // Single add, 2-cycle accept-to-start latency, one irq pulse
    base_irq = irq_cnt;
    push(32'h3F80_0000, 32'h3F8C_CCCD, FPU_OP_ADD, 4'd3, "t1_push");
    chk("t1_start_cycle1", 32'(fpu_start), 32'd0);
    tick(1);
    chk("t1_start_cycle2", 32'(fpu_start), 32'd1);
    chk("t1_a_operand", fpu_a_operand, 32'h3F80_0000);
    chk("t1_b_operand", fpu_b_operand, 32'h3F8C_CCCD);
    chk("t1_operation", 32'(fpu_operation), 32'(FPU_OP_ADD));
    wait_rsp("t1_rsp_wait");
    tick(3);
    chk("t1_rsp_held", 32'(rsp_valid), 32'd1);
    chk("t1_result", rsp_result, 32'h4006_6666);
    chk("t1_tag", 32'(rsp_tag), 32'd3);
    chk("t1_timeout", 32'(rsp_timeout), 32'd0);
    chk("t1_irq_pulses", 32'(irq_cnt - base_irq), 32'd1);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    chk("t1_rsp_dropped", 32'(rsp_valid), 32'd0);
    chk("t1_seq_idle", 32'(seq_busy), 32'd0);

    // Back-pressure: one in flight plus four queued fills the FIFO
    qb = got_tag.size();
    for (int i = 0; i < 5; i++)
      push(32'h1000_0000 + 32'(i), 32'h0, FPU_OP_MUL, TAG_W'(i), "t2_push");
    chk("t2_full_ready_low", 32'(req_ready), 32'd0);
    chk("t2_seq_busy", 32'(seq_busy), 32'd1);
    wait_rsp("t2_rsp0_wait");
    chk("t2_rsp0_tag", 32'(rsp_tag), 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    // IDLE with a full FIFO: the pop frees a slot for a push in the same cycle
    chk("t2_full_pop_ready", 32'(req_ready), 32'd1);
    push(32'h1000_0005, 32'h0, FPU_OP_MUL, 4'd5, "t2_push_on_full");
    chk("t2_count_unchanged", 32'(req_ready), 32'd0);
    chk("t2_issued_next", fpu_a_operand, 32'h1000_0001);
    rsp_ready = 1'b1;
    wait_q(qb + 6, "t2_drain_wait");
    for (int i = 0; i < 6; i++) begin
      chk("t2_drain_tag", 32'(got_tag[qb+i]), 32'(i));
      chk("t2_drain_result", got_res[qb+i], 32'h1000_0000 + 32'(i));
    end
    tick(2);
    rsp_ready = 1'b0;

    // Timeout: responder never signals completion
    no_end = 1'b1;
    push(32'h0000_0001, 32'h0000_0002, FPU_OP_DIV, 4'd7, "t3_push");
    tick(1);
    n = 0;
    while (fpu_start === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
    chk("t3_start_cycles", 32'(n), 32'd16);
    wait_rsp("t3_rsp_wait");
    chk("t3_result_qnan", rsp_result, 32'h7FC0_0000);
    chk("t3_timeout_flag", 32'(rsp_timeout), 32'd1);
    chk("t3_tag", 32'(rsp_tag), 32'd7);
    no_end = 1'b0;
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // External busy holds off issue
    ext_busy = 1'b1;
    push(32'h3F80_0000, 32'h3F8C_CCCD, FPU_OP_ADD, 4'd9, "t4_push");
    tick(4);
    chk("t4_no_start", 32'(fpu_start), 32'd0);
    chk("t4_seq_busy", 32'(seq_busy), 32'd1);
    ext_busy = 1'b0;
    chk("t4_not_yet", 32'(fpu_start), 32'd0);
    tick(1);
    chk("t4_issue_after_busy", 32'(fpu_start), 32'd1);
    wait_rsp("t4_rsp_wait");
    chk("t4_result", rsp_result, 32'h4006_6666);
    chk("t4_tag", 32'(rsp_tag), 32'd9);
    chk("t4_timeout", 32'(rsp_timeout), 32'd0);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;

    // Twelve subtracts streamed through the FIFO, wrapping its pointers
    qb = got_tag.size();
    rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++)
      push(32'h3F80_0000, 32'h3F8C_CCCD, FPU_OP_SUB, TAG_W'(i), "t5_push");
    wait_q(qb + 12, "t5_wait");
    for (int i = 0; i < 12; i++) begin
      chk("t5_tag", 32'(got_tag[qb+i]), 32'(i));
      chk("t5_result", got_res[qb+i], 32'hBDCC_CCD0);
    end
    tick(2);
    rsp_ready = 1'b0;
    chk("t5_seq_idle", 32'(seq_busy), 32'd0);

    // Reset while an op is being issued and another is queued
    push(32'h3F80_0000, 32'h3F8C_CCCD, FPU_OP_ADD, 4'd2, "t6_push_a");
    push(32'h0000_0005, 32'h0000_0005, FPU_OP_MUL, 4'd4, "t6_push_b");
    chk("t6_issuing", 32'(fpu_start), 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("t6_rst_start", 32'(fpu_start), 32'd0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_seq_busy", 32'(seq_busy), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd0);
    tick(1);
    arst_n = 1'b1;
    tick(1);
    qb = got_tag.size();
    rsp_ready = 1'b1;
    push(32'h3F80_0000, 32'h3F8C_CCCD, FPU_OP_ADD, 4'd6, "t6_push_new");
    wait_q(qb + 1, "t6_wait");
    chk("t6_tag", 32'(got_tag[qb]), 32'd6);
    chk("t6_result", got_res[qb], 32'h4006_6666);
    tick(20);
    chk("t6_no_stale_rsp", 32'(got_tag.size()), 32'(qb + 1));
    chk("t6_seq_idle", 32'(seq_busy), 32'd0);
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fpu_cmd_initiator.md
Name: fpu_cmd_initiator

Overview:
- Bus-side initiator for the fpu core.
- Accepts operation requests (a, b, op, tag) over a valid/ready interface and buffers them in a small FIFO.
- Issues requests one at a time to the fpu using its start/cmd_end/busy handshake, captures ieee_packet_out, and returns results over a valid/ready response port.
- Sits between the CPU register file/microcode and the fpu; it is the driving end of the interface the fpu responds to.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of two, >= 2.
- TAG_W, 4, width of the request tag echoed on the response.
- TIMEOUT_CYCLES, 64, maximum cycles from fpu_start rising to fpu_cmd_end high before the op is aborted.

Ports:
- clk  in  1  system clock.
- arst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request FIFO not full.
- req_a  in  32  IEEE-754 operand A.
- req_b  in  32  IEEE-754 operand B.
- req_op  in  pa_fpu::e_fpu_op  operation.
- req_tag  in  TAG_W  caller tag.
- fpu_start  out  1  to fpu start.
- fpu_a_operand  out  32  to fpu a_operand.
- fpu_b_operand  out  32  to fpu b_operand.
- fpu_operation  out  pa_fpu::e_fpu_op  to fpu operation.
- fpu_cmd_end  in  1  from fpu cmd_end.
- fpu_busy  in  1  from fpu busy.
- fpu_result  in  32  from fpu ieee_packet_out.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_result  out  32  captured result.
- rsp_tag  out  TAG_W  tag of the completed request.
- rsp_timeout  out  1  op aborted by timeout.
- irq  out  1  one-cycle pulse when rsp_valid rises.
- seq_busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- Reset: while arst_n is low, all outputs are 0, fpu_operation is the zero enum value, the FIFO is empty, and the FSM is in IDLE. req_ready goes to 1 on the first clock after release.
- FIFO:
  - Push on req_valid && req_ready; pop when IDLE and the FIFO is non-empty.
  - A push and pop in the same cycle are both legal, including when the FIFO is full: a pop frees the slot in the same cycle, so req_ready = !full || pop.
  - Pointers wrap modulo FIFO_DEPTH.
  - Count width is clog2(FIFO_DEPTH)+1.
- IDLE:
  - Stays in IDLE if the FIFO is empty, or if the FIFO is non-empty but fpu_busy=1.
  - If the FIFO is non-empty and fpu_busy=0: pop, register a/b/op/tag onto the fpu_* outputs, go to ISSUE.
- ISSUE:
  - fpu_start=1; operands are held stable; the timeout counter increments each cycle.
  - When fpu_cmd_end=1 is sampled: deassert fpu_start next cycle, capture fpu_result into rsp_result, rsp_timeout=0, go to WAIT_END.
  - When the counter reaches TIMEOUT_CYCLES-1 with no cmd_end: deassert fpu_start, rsp_result=32'h7FC00000, rsp_timeout=1, go to WAIT_END.
- WAIT_END:
  - Waits for fpu_cmd_end=0 and fpu_busy=0, so the same completion is never double-counted.
  - Then goes to RESP, sets rsp_valid=1 and pulses irq for one cycle.
- RESP:
  - rsp_valid, rsp_result, rsp_tag and rsp_timeout are held until rsp_ready=1.
  - On that cycle rsp_valid drops and the FSM returns to IDLE.
  - If the FIFO is non-empty, the next issue occurs on the following cycle; issue is not overlapped with the response.
- Latency: best case from req accept to fpu_start is 2 cycles (FIFO write, then IDLE pop).
- fpu_cmd_end asserted in IDLE/RESP is ignored.
- Reset mid-operation: asynchronous clear, fpu_start drops immediately, any pending response is lost.
- The fpu_* operand outputs are registers and change only on the IDLE->ISSUE transition.

Decomposition:
- Add to pa_fpu:
  - e_fpu_init_state {INIT_IDLE, INIT_ISSUE, INIT_WAIT_END, INIT_RESP}.
  - st_fpu_req struct {a, b, op, tag} with the tag sized by a package constant FPU_TAG_W_MAX.
  - Constant FPU_QNAN = 32'h7FC00000.
- Sub-module fpu_req_fifo: a synchronous FIFO of st_fpu_req, parameterised by depth, with full/empty flags.

Test Plan:
- Single op, with a behavioural fpu responder at 5-cycle latency: push a=3f800000, b=3f8ccccd, op_add, tag=3 -> fpu_start high 2 cycles later; rsp_result=40066666, rsp_tag=3, rsp_timeout=0; one irq pulse.
- Back-pressure: hold rsp_ready=0 and push 5 requests with FIFO_DEPTH=4 -> req_ready falls after the 4th queued entry (one entry already in flight); releasing rsp_ready drains results in order, tags 0..4.
- Timeout: responder never asserts cmd_end, TIMEOUT_CYCLES=16 -> fpu_start high exactly 16 cycles; then rsp_result=7FC00000, rsp_timeout=1.
- fpu_busy=1 held externally with the FIFO non-empty -> no fpu_start until busy falls; issue occurs on the cycle after busy=0.
- Simultaneous push and pop on a full FIFO -> entry accepted, count unchanged, no data loss, and order is preserved across pointer wrap-around (push 12 ops: 3f800000 - 3f8ccccd, op_sub, each result tagged correctly).
- Reset mid-ISSUE: drop arst_n while fpu_start=1 -> fpu_start, rsp_valid and seq_busy go to 0 immediately, FIFO empty; a new request after release completes normally.
